// File: rtl/logic_unit_acc.sv
// Purpose: registered WIDTH-bit bitwise logic unit with an optional fold-into-accumulator mode.
// Latency: 1 cycle from input accept to y/out_valid; one result per cycle when not stalled.
// Backpressure: single output register; in_ready = !out_valid | out_ready, all state holds on stall.
module logic_unit_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             acc_en_i,
  input  logic             acc_clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             ones_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_MAX - CNT_MAX + 1'b1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             accept;
  logic [WIDTH-1:0] fold_res;
  logic [WIDTH-1:0] pair_res;

  // Pure bitwise operation table; no carries, result is exactly WIDTH bits.
  function automatic logic [WIDTH-1:0] bit_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = x & z;
      3'b001:  r = x | z;
      3'b010:  r = x ^ z;
      3'b011:  r = ~(x & z);
      3'b100:  r = ~(x | z);
      3'b101:  r = ~(x ^ z);
      3'b110:  r = x & ~z;
      default: r = x;
    endcase
    return r;
  endfunction

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  // In fold mode the accumulator takes the left-hand operand slot and a the right.
  assign fold_res   = bit_op(op_i, acc_q, a_i);
  assign pair_res   = bit_op(op_i, a_i, b_i);

  // Next-state: new result on accept, drop valid on drain, otherwise hold everything.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    count_d     = count_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (acc_en_i) begin
        if (acc_clr_i) begin
          acc_d   = a_i;
          y_d     = a_i;
          count_d = CNT_ONE;
        end else begin
          acc_d   = fold_res;
          y_d     = fold_res;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        end
      end else begin
        y_d = pair_res;
      end
      // Flags describe the freshly registered y, so derive them from y_d.
      zero_d = (y_d == '0);
      ones_d = (y_d == '1);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides any pending output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      count_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign zero_o      = zero_q;
  assign ones_o      = ones_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Bench for logic_unit_acc: directed vectors drive the input side, expected results queue up
// on accept, and an independent monitor pops and compares whenever an output is consumed.
module tb_logic_unit_acc;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] a_i, b_i;
  logic [2:0] op_i;
  logic       acc_en_i, acc_clr_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] y_o;
  logic       zero_o, ones_o;
  logic [3:0] count_o;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic_unit_acc #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .acc_en_i    (acc_en_i),
    .acc_clr_i   (acc_clr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .y_o         (y_o),
    .zero_o      (zero_o),
    .ones_o      (ones_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one input and wait for it to be accepted; the expected result is queued at accept.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic en, input logic clr,
                      input logic [7:0] ey, input logic [3:0] ec, input bit push);
    bit got;
    got        = 1'b0;
    a_i        = a;
    b_i        = b;
    op_i       = op;
    acc_en_i   = en;
    acc_clr_i  = clr;
    in_valid_i = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (in_ready_o === 1'b1) begin
        got = 1'b1;
        if (push) sb.push_back(exp_t'{ey, (ey == 8'h00), (ey == 8'hFF), ec});
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    chk("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  // Monitor: every output consumed by downstream must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got y=%h count=%0d, expected no output", y_o, count_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result{y,zero,ones,count}", {18'd0, y_o, zero_o, ones_o, count_o},
              {18'd0, e.y, e.z, e.o, e.c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with in_valid asserted.
    reset_i     = 1'b1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    a_i = 8'hFF; b_i = 8'hFF; op_i = 3'd1; acc_en_i = 1'b0; acc_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset_y", {24'd0, y_o}, 32'd0);
    chk("reset_count", {28'd0, count_o}, 32'd0);
    chk("reset_zero_ones", {30'd0, zero_o, ones_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("in_ready_after_reset", {31'd0, in_ready_o}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // All eight ops on a=F0, b=3C, back to back.
    send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 8'h30, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd1, 1'b0, 1'b0, 8'hFC, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd2, 1'b0, 1'b0, 8'hCC, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd3, 1'b0, 1'b0, 8'hCF, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd4, 1'b0, 1'b0, 8'h03, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd5, 1'b0, 1'b0, 8'h33, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd6, 1'b0, 1'b0, 8'hC0, 4'd0, 1'b1);
    send(8'hF0, 8'h3C, 3'd7, 1'b0, 1'b0, 8'hF0, 4'd0, 1'b1);

    // AND-reduce of a short stream, then a fresh stream starting at zero.
    send(8'hFF, 8'h00, 3'd7, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b1);
    send(8'hF7, 8'h00, 3'd0, 1'b1, 1'b0, 8'hF7, 4'd2, 1'b1);
    send(8'h7F, 8'h00, 3'd0, 1'b1, 1'b0, 8'h77, 4'd3, 1'b1);
    send(8'hFE, 8'h00, 3'd0, 1'b1, 1'b0, 8'h76, 4'd4, 1'b1);
    send(8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'h00, 4'd1, 1'b1);

    // Backpressure: stall three cycles with a new input waiting.
    send(8'h55, 8'h0F, 3'd0, 1'b0, 1'b0, 8'h05, 4'd1, 1'b1);
    out_ready_i = 1'b0;
    a_i = 8'hAA; b_i = 8'h55; op_i = 3'd1; acc_en_i = 1'b0; acc_clr_i = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("stall_y_held", {24'd0, y_o}, 32'h05);
      chk("stall_out_valid", {31'd0, out_valid_o}, 32'd1);
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("stall_release_in_ready", {31'd0, in_ready_o}, 32'd1);
    sb.push_back(exp_t'{8'hFF, 1'b0, 1'b1, 4'd1});
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;

    // Counter saturation: clear then 20 XOR folds of 01, then ones/zero flag checks.
    send(8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'h00, 4'd1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0, (k % 2 == 1) ? 8'h01 : 8'h00,
           (k + 1 > 15) ? 4'd15 : 4'(k + 1), 1'b1);
    end
    send(8'hFF, 8'h00, 3'd1, 1'b1, 1'b0, 8'hFF, 4'd15, 1'b1);
    send(8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 4'd15, 1'b1);

    // Reset mid-stream with a stalled output; the held result is dropped.
    send(8'h3C, 8'h00, 3'd0, 1'b1, 1'b1, 8'h3C, 4'd1, 1'b0);
    out_ready_i = 1'b0;
    @(negedge clk_i);
    chk("pre_reset_out_valid", {31'd0, out_valid_o}, 32'd1);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("mid_reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("mid_reset_y_count", {20'd0, y_o, count_o}, 32'd0);
    chk("mid_reset_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    send(8'h0F, 8'h00, 3'd1, 1'b1, 1'b0, 8'h0F, 4'd1, 1'b1);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
